// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for a five-stage pipeline: load-use stall, branch
// flush, data-memory wait stall, operand forwarding and a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1D,
  input  logic [4:0]      rs2D,
  input  logic [4:0]      rs1E,
  input  logic [4:0]      rs2E,
  input  logic [4:0]      rdE,
  input  logic [4:0]      rdM,
  input  logic [4:0]      rdW,
  input  logic            loadE,
  input  logic            regWriteM,
  input  logic            regWriteW,
  input  logic            PCSrcE,
  input  logic            memReqM,
  input  logic            memReadyM,
  output logic            stallF,
  output logic            stallD,
  output logic            stallE,
  output logic            stallM,
  output logic            flushD,
  output logic            flushE,
  output logic [1:0]      forwardAE,
  output logic [1:0]      forwardBE,
  output logic [CNTW-1:0] stallCnt
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    MWAIT = 1'b1
  } state_e;

  state_e          state_q;
  state_e          state_d;
  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_d;

  logic mem_wait;
  logic lw_stall;

  // x0 is hard-wired to zero, so it can never be the source of a hazard or forward.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       wr_m,
    input logic [4:0] rd_m,
    input logic       wr_w,
    input logic [4:0] rd_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    mem_wait = memReqM & ~memReadyM;
    lw_stall = loadE & (rdE != 5'd0) & ((rdE == rs1D) | (rdE == rs2D));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (mem_wait) begin
          state_d = MWAIT;
        end
      end
      MWAIT: begin
        if (memReadyM) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // The wait is judged from the live inputs in both states, so the first wait cycle
  // stalls immediately and a ready response releases the stall in the same cycle.
  // A taken branch seen during a wait stays in E and flushes once the wait ends.
  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    stallM = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    if (mem_wait) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
    end else if (PCSrcE) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (lw_stall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

  always_comb begin
    forwardAE = fwd_sel(rs1E, regWriteM, rdM, regWriteW, rdW);
    forwardBE = fwd_sel(rs2E, regWriteM, rdM, regWriteW, rdW);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stallF && (cnt_q != {CNTW{1'b1}})) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stallCnt = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a default-width and a 4-bit-counter
// instance share the stimulus; expected control words are queued per cycle.
module tb_pipe_hazard_ctrl;

  localparam logic [9:0] C_IDLE = 10'b000000_00_00;
  localparam logic [9:0] C_LW   = 10'b110001_00_00;
  localparam logic [9:0] C_MEM  = 10'b111100_00_00;
  localparam logic [9:0] C_BR   = 10'b000011_00_00;

  typedef struct {
    logic       rst;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       loadE, regWriteM, regWriteW, PCSrcE, memReqM, memReadyM;
  } stim_t;

  typedef struct {
    logic [9:0]  ctl;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic loadE, regWriteM, regWriteW, PCSrcE, memReqM, memReadyM;
  logic stallF, stallD, stallE, stallM, flushD, flushE;
  logic [1:0] forwardAE, forwardBE;
  logic [15:0] stallCnt;
  logic stallF4, stallD4, stallE4, stallM4, flushD4, flushE4;
  logic [1:0] forwardAE4, forwardBE4;
  logic [3:0] stallCnt4;
  logic [9:0] ctl;

  exp_t        sb[$];
  logic [15:0] cnt_m = '0;
  logic [3:0]  cnt4_m = '0;
  int          total = 0;
  int          bad = 0;

  assign ctl = {stallF, stallD, stallE, stallM, flushD, flushE, forwardAE, forwardBE};

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW),
    .loadE(loadE), .regWriteM(regWriteM), .regWriteW(regWriteW),
    .PCSrcE(PCSrcE), .memReqM(memReqM), .memReadyM(memReadyM),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallCnt(stallCnt)
  );

  pipe_hazard_ctrl #(.CNTW(4)) dut4 (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW),
    .loadE(loadE), .regWriteM(regWriteM), .regWriteW(regWriteW),
    .PCSrcE(PCSrcE), .memReqM(memReqM), .memReadyM(memReadyM),
    .stallF(stallF4), .stallD(stallD4), .stallE(stallE4), .stallM(stallM4),
    .flushD(flushD4), .flushE(flushE4),
    .forwardAE(forwardAE4), .forwardBE(forwardBE4),
    .stallCnt(stallCnt4)
  );

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b1;
    s.rs1D = 5'd0; s.rs2D = 5'd0; s.rs1E = 5'd0; s.rs2E = 5'd0;
    s.rdE = 5'd0;  s.rdM = 5'd0;  s.rdW = 5'd0;
    s.loadE = 1'b0; s.regWriteM = 1'b0; s.regWriteW = 1'b0;
    s.PCSrcE = 1'b0; s.memReqM = 1'b0; s.memReadyM = 1'b0;
    return s;
  endfunction

  // Drives one cycle of stimulus just after the rising edge and queues what the
  // outputs must be at mid-cycle; the counter model counts cycles with stallF set.
  task automatic applyStimulus(input stim_t s, input logic [9:0] c);
    exp_t e;
    @(posedge clk);
    #1;
    rst = s.rst;
    rs1D = s.rs1D; rs2D = s.rs2D; rs1E = s.rs1E; rs2E = s.rs2E;
    rdE = s.rdE; rdM = s.rdM; rdW = s.rdW;
    loadE = s.loadE; regWriteM = s.regWriteM; regWriteW = s.regWriteW;
    PCSrcE = s.PCSrcE; memReqM = s.memReqM; memReadyM = s.memReadyM;
    e.ctl  = c;
    e.cnt  = s.rst ? cnt_m : 16'd0;
    e.cnt4 = s.rst ? cnt4_m : 4'd0;
    sb.push_back(e);
    if (!s.rst) begin
      cnt_m  = '0;
      cnt4_m = '0;
    end else if (c[9]) begin
      if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
      if (cnt4_m != 4'hF) cnt4_m = cnt4_m + 4'd1;
    end
  endtask

  task automatic test_reset();
    stim_t sv[$];
    logic [9:0] cv[$];
    stim_t s;
    exp_t e;
    s = idle(); s.rst = 1'b0; sv.push_back(s); cv.push_back(C_IDLE);
    s = idle(); s.rst = 1'b0; s.loadE = 1'b1; s.rdE = 5'd5; s.rs1D = 5'd5;
    sv.push_back(s); cv.push_back(C_LW);
    s = idle(); s.rst = 1'b0; s.memReqM = 1'b1; sv.push_back(s); cv.push_back(C_MEM);
    s = idle(); s.rst = 1'b0; sv.push_back(s); cv.push_back(C_IDLE);
    foreach (sv[i]) begin
      applyStimulus(sv[i], cv[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (ctl !== e.ctl) begin
        bad++; $display("[TB] FAIL reset[%0d] ctl got %b want %b", i, ctl, e.ctl);
      end
      total++;
      if (stallCnt !== e.cnt || stallCnt4 !== e.cnt4) begin
        bad++; $display("[TB] FAIL reset[%0d] cnt got %0d/%0d want %0d/%0d", i, stallCnt, stallCnt4, e.cnt, e.cnt4);
      end
    end
  endtask

  task automatic test_load_use();
    stim_t sv[$];
    logic [9:0] cv[$];
    stim_t s;
    exp_t e;
    s = idle(); s.loadE = 1'b1; s.rdE = 5'd5; s.rs1D = 5'd5; sv.push_back(s); cv.push_back(C_LW);
    s = idle(); sv.push_back(s); cv.push_back(C_IDLE);
    s = idle(); s.loadE = 1'b1; sv.push_back(s); cv.push_back(C_IDLE);
    s = idle(); s.loadE = 1'b1; s.rdE = 5'd9; s.rs1D = 5'd3; s.rs2D = 5'd9;
    sv.push_back(s); cv.push_back(C_LW);
    s = idle(); s.rdE = 5'd5; s.rs1D = 5'd5; sv.push_back(s); cv.push_back(C_IDLE);
    s = idle(); s.loadE = 1'b1; s.rdE = 5'd6; s.rs1D = 5'd7; s.rs2D = 5'd8;
    sv.push_back(s); cv.push_back(C_IDLE);
    s = idle(); sv.push_back(s); cv.push_back(C_IDLE);
    foreach (sv[i]) begin
      applyStimulus(sv[i], cv[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (ctl !== e.ctl) begin
        bad++; $display("[TB] FAIL load_use[%0d] ctl got %b want %b", i, ctl, e.ctl);
      end
      total++;
      if (stallCnt !== e.cnt || stallCnt4 !== e.cnt4) begin
        bad++; $display("[TB] FAIL load_use[%0d] cnt got %0d/%0d want %0d/%0d", i, stallCnt, stallCnt4, e.cnt, e.cnt4);
      end
    end
  endtask

  task automatic test_forward();
    stim_t sv[$];
    logic [9:0] cv[$];
    stim_t s;
    exp_t e;
    s = idle(); s.regWriteM = 1'b1; s.regWriteW = 1'b1; s.rdM = 5'd7; s.rdW = 5'd7; s.rs1E = 5'd7;
    sv.push_back(s); cv.push_back(10'b000000_10_00);
    s.rdM = 5'd3; sv.push_back(s); cv.push_back(10'b000000_01_00);
    s.rdW = 5'd0; s.rs1E = 5'd0; sv.push_back(s); cv.push_back(10'b000000_00_00);
    s = idle(); s.regWriteW = 1'b1; s.rdM = 5'd7; s.rdW = 5'd7; s.rs2E = 5'd7;
    sv.push_back(s); cv.push_back(10'b000000_00_01);
    s = idle(); s.regWriteM = 1'b1; s.regWriteW = 1'b1; s.rdM = 5'd4; s.rdW = 5'd6;
    s.rs1E = 5'd4; s.rs2E = 5'd6; sv.push_back(s); cv.push_back(10'b000000_10_01);
    s = idle(); s.regWriteM = 1'b1; s.rdM = 5'd2; s.rs1E = 5'd2; s.rs2E = 5'd2;
    sv.push_back(s); cv.push_back(10'b000000_10_10);
    s = idle(); s.regWriteM = 1'b1; s.regWriteW = 1'b1; s.rs1E = 5'd9; s.rs2E = 5'd9;
    s.rdM = 5'd8; s.rdW = 5'd10; sv.push_back(s); cv.push_back(C_IDLE);
    foreach (sv[i]) begin
      applyStimulus(sv[i], cv[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (ctl !== e.ctl) begin
        bad++; $display("[TB] FAIL forward[%0d] ctl got %b want %b", i, ctl, e.ctl);
      end
    end
  endtask

  task automatic test_branch();
    stim_t sv[$];
    logic [9:0] cv[$];
    stim_t s;
    exp_t e;
    s = idle(); s.PCSrcE = 1'b1; s.loadE = 1'b1; s.rdE = 5'd12; s.rs2D = 5'd12;
    sv.push_back(s); cv.push_back(C_BR);
    s = idle(); s.PCSrcE = 1'b1; sv.push_back(s); cv.push_back(C_BR);
    s = idle(); sv.push_back(s); cv.push_back(C_IDLE);
    foreach (sv[i]) begin
      applyStimulus(sv[i], cv[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (ctl !== e.ctl) begin
        bad++; $display("[TB] FAIL branch[%0d] ctl got %b want %b", i, ctl, e.ctl);
      end
      total++;
      if (stallCnt !== e.cnt || stallCnt4 !== e.cnt4) begin
        bad++; $display("[TB] FAIL branch[%0d] cnt got %0d/%0d want %0d/%0d", i, stallCnt, stallCnt4, e.cnt, e.cnt4);
      end
    end
  endtask

  task automatic test_mem_wait();
    stim_t sv[$];
    logic [9:0] cv[$];
    stim_t s;
    exp_t e;
    s = idle(); s.rst = 1'b0; sv.push_back(s); cv.push_back(C_IDLE);
    for (int k = 0; k < 3; k++) begin
      s = idle(); s.memReqM = 1'b1; sv.push_back(s); cv.push_back(C_MEM);
    end
    s = idle(); s.memReqM = 1'b1; s.memReadyM = 1'b1; sv.push_back(s); cv.push_back(C_IDLE);
    s = idle(); sv.push_back(s); cv.push_back(C_IDLE);
    s = idle(); s.memReqM = 1'b1; s.loadE = 1'b1; s.rdE = 5'd5; s.rs1D = 5'd5;
    s.regWriteM = 1'b1; s.rdM = 5'd3; s.rs1E = 5'd3;
    sv.push_back(s); cv.push_back(10'b111100_10_00);
    s.memReadyM = 1'b1; sv.push_back(s); cv.push_back(10'b110001_10_00);
    s = idle(); sv.push_back(s); cv.push_back(C_IDLE);
    foreach (sv[i]) begin
      applyStimulus(sv[i], cv[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (ctl !== e.ctl) begin
        bad++; $display("[TB] FAIL mem_wait[%0d] ctl got %b want %b", i, ctl, e.ctl);
      end
      total++;
      if (stallCnt !== e.cnt || stallCnt4 !== e.cnt4) begin
        bad++; $display("[TB] FAIL mem_wait[%0d] cnt got %0d/%0d want %0d/%0d", i, stallCnt, stallCnt4, e.cnt, e.cnt4);
      end
    end
  endtask

  task automatic test_deferred_flush();
    stim_t sv[$];
    logic [9:0] cv[$];
    stim_t s;
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      s = idle(); s.memReqM = 1'b1; s.PCSrcE = 1'b1; sv.push_back(s); cv.push_back(C_MEM);
    end
    s = idle(); s.memReqM = 1'b1; s.memReadyM = 1'b1; s.PCSrcE = 1'b1;
    sv.push_back(s); cv.push_back(C_BR);
    s = idle(); sv.push_back(s); cv.push_back(C_IDLE);
    foreach (sv[i]) begin
      applyStimulus(sv[i], cv[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (ctl !== e.ctl) begin
        bad++; $display("[TB] FAIL deferred_flush[%0d] ctl got %b want %b", i, ctl, e.ctl);
      end
      total++;
      if (stallCnt !== e.cnt || stallCnt4 !== e.cnt4) begin
        bad++; $display("[TB] FAIL deferred_flush[%0d] cnt got %0d/%0d want %0d/%0d", i, stallCnt, stallCnt4, e.cnt, e.cnt4);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t sv[$];
    logic [9:0] cv[$];
    stim_t s;
    exp_t e;
    s = idle(); s.loadE = 1'b1; s.rdE = 5'd20; s.rs1D = 5'd20; sv.push_back(s); cv.push_back(C_LW);
    s = idle(); s.PCSrcE = 1'b1; s.regWriteW = 1'b1; s.rdW = 5'd20; s.rs2E = 5'd20;
    sv.push_back(s); cv.push_back(10'b000011_00_01);
    s = idle(); s.memReqM = 1'b1; sv.push_back(s); cv.push_back(C_MEM);
    s = idle(); s.loadE = 1'b1; s.rdE = 5'd31; s.rs2D = 5'd31; sv.push_back(s); cv.push_back(C_LW);
    s = idle(); s.loadE = 1'b1; s.rdE = 5'd1; s.rs1D = 5'd1; s.rs2D = 5'd1;
    sv.push_back(s); cv.push_back(C_LW);
    s = idle(); sv.push_back(s); cv.push_back(C_IDLE);
    foreach (sv[i]) begin
      applyStimulus(sv[i], cv[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (ctl !== e.ctl) begin
        bad++; $display("[TB] FAIL back_to_back[%0d] ctl got %b want %b", i, ctl, e.ctl);
      end
      total++;
      if (stallCnt !== e.cnt || stallCnt4 !== e.cnt4) begin
        bad++; $display("[TB] FAIL back_to_back[%0d] cnt got %0d/%0d want %0d/%0d", i, stallCnt, stallCnt4, e.cnt, e.cnt4);
      end
    end
  endtask

  task automatic test_saturation();
    stim_t sv[$];
    logic [9:0] cv[$];
    stim_t s;
    exp_t e;
    s = idle(); s.rst = 1'b0; sv.push_back(s); cv.push_back(C_IDLE);
    for (int k = 0; k < 20; k++) begin
      s = idle(); s.loadE = 1'b1; s.rdE = 5'd5; s.rs1D = 5'd5; sv.push_back(s); cv.push_back(C_LW);
    end
    for (int k = 0; k < 2; k++) begin
      s = idle(); s.memReqM = 1'b1; sv.push_back(s); cv.push_back(C_MEM);
    end
    foreach (sv[i]) begin
      applyStimulus(sv[i], cv[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (ctl !== e.ctl) begin
        bad++; $display("[TB] FAIL saturation[%0d] ctl got %b want %b", i, ctl, e.ctl);
      end
      total++;
      if (stallCnt !== e.cnt || stallCnt4 !== e.cnt4) begin
        bad++; $display("[TB] FAIL saturation[%0d] cnt got %0d/%0d want %0d/%0d", i, stallCnt, stallCnt4, e.cnt, e.cnt4);
      end
    end
    // Reset lands between edges while the memory wait is still active.
    #1;
    rst = 1'b0;
    #1;
    total++;
    if (stallCnt !== 16'd0 || stallCnt4 !== 4'd0) begin
      bad++; $display("[TB] FAIL async_reset cnt got %0d/%0d want 0/0", stallCnt, stallCnt4);
    end
    total++;
    if (ctl !== C_MEM) begin
      bad++; $display("[TB] FAIL async_reset ctl got %b want %b", ctl, C_MEM);
    end
    cnt_m  = '0;
    cnt4_m = '0;
    sv.delete();
    cv.delete();
    s = idle(); sv.push_back(s); cv.push_back(C_IDLE);
    s = idle(); s.memReqM = 1'b1; s.memReadyM = 1'b1; sv.push_back(s); cv.push_back(C_IDLE);
    s = idle(); s.loadE = 1'b1; s.rdE = 5'd2; s.rs2D = 5'd2; sv.push_back(s); cv.push_back(C_LW);
    s = idle(); sv.push_back(s); cv.push_back(C_IDLE);
    foreach (sv[i]) begin
      applyStimulus(sv[i], cv[i]);
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (ctl !== e.ctl) begin
        bad++; $display("[TB] FAIL post_reset[%0d] ctl got %b want %b", i, ctl, e.ctl);
      end
      total++;
      if (stallCnt !== e.cnt || stallCnt4 !== e.cnt4) begin
        bad++; $display("[TB] FAIL post_reset[%0d] cnt got %0d/%0d want %0d/%0d", i, stallCnt, stallCnt4, e.cnt, e.cnt4);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0;
    rdE = '0; rdM = '0; rdW = '0;
    loadE = 1'b0; regWriteM = 1'b0; regWriteW = 1'b0;
    PCSrcE = 1'b0; memReqM = 1'b0; memReadyM = 1'b0;
    test_reset();
    test_load_use();
    test_forward();
    test_branch();
    test_mem_wait();
    test_deferred_flush();
    test_back_to_back();
    test_saturation();
    total++;
    if (sb.size() != 0) begin
      bad++; $display("[TB] FAIL scoreboard_drain left %0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
